// File: rtl/instr_fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_fetch_sequencer                                         |
// | Brief    : PC-driven fetch/decode/issue sequencer for a small core array;|
// |            optional busy-cycle counter enabled by FETCH_CYCLE_CNT_EN.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module instr_fetch_sequencer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] instruction,
  input  logic       z_flag,
  input  logic       exec_done,
  output logic [7:0] addr,
  output logic [7:0] opcode,
  output logic       opcode_valid,
  output logic [3:0] core_en,
  output logic       busy,
  output logic       halted
`ifdef FETCH_CYCLE_CNT_EN
  ,
  output logic [15:0] cycle_cnt
`endif
);

  localparam logic [7:0] c_op_en0    = 8'd3;
  localparam logic [7:0] c_op_en1    = 8'd4;
  localparam logic [7:0] c_op_en2    = 8'd5;
  localparam logic [7:0] c_op_en3    = 8'd6;
  localparam logic [7:0] c_op_enall  = 8'd7;
  localparam logic [7:0] c_op_rstall = 8'd8;
  localparam logic [7:0] c_op_end    = 8'd38;
  localparam logic [7:0] c_op_jumnz  = 8'd40;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_ISSUE    = 3'd3,
    S_EXEC     = 3'd4,
    S_OPFETCH  = 3'd5,
    S_OPDECODE = 3'd6,
    S_HALT     = 3'd7
  } state_t;

  state_t     r_state;
  logic [7:0] r_pc;
  logic [7:0] w_pc_inc;
  logic [7:0] w_pc_inc2;

  assign w_pc_inc  = r_pc + 8'd1;
  assign w_pc_inc2 = r_pc + 8'd2;

  // addr tracks the PC except during the JUMNZ operand fetch at pc+1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_pc         <= 8'd0;
      addr         <= 8'd0;
      opcode       <= 8'd0;
      opcode_valid <= 1'b0;
      core_en      <= 4'b0000;
      busy         <= 1'b0;
      halted       <= 1'b0;
    end else begin
      opcode_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_pc    <= 8'd0;
            addr    <= 8'd0;
            busy    <= 1'b1;
            halted  <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          case (instruction)
            c_op_en0, c_op_en1, c_op_en2, c_op_en3, c_op_enall: begin
              case (instruction)
                c_op_en0: core_en <= 4'b0001;
                c_op_en1: core_en <= 4'b0010;
                c_op_en2: core_en <= 4'b0100;
                c_op_en3: core_en <= 4'b1000;
                default:  core_en <= 4'b1111;
              endcase
              r_pc    <= w_pc_inc;
              addr    <= w_pc_inc;
              r_state <= S_FETCH;
            end
            c_op_end: begin
              busy    <= 1'b0;
              halted  <= 1'b1;
              r_state <= S_HALT;
            end
            c_op_jumnz: begin
              addr    <= w_pc_inc;
              r_state <= S_OPFETCH;
            end
            default: begin
              // RSTALL is still forwarded to the datapath after clearing the mask.
              if (instruction == c_op_rstall) core_en <= 4'b0000;
              opcode       <= instruction;
              opcode_valid <= 1'b1;
              r_state      <= S_ISSUE;
            end
          endcase
        end
        S_ISSUE: r_state <= S_EXEC;
        S_EXEC: begin
          if (exec_done) begin
            r_pc    <= w_pc_inc;
            addr    <= w_pc_inc;
            r_state <= S_FETCH;
          end
        end
        S_OPFETCH: r_state <= S_OPDECODE;
        S_OPDECODE: begin
          if (!z_flag) begin
            r_pc <= instruction;
            addr <= instruction;
          end else begin
            r_pc <= w_pc_inc2;
            addr <= w_pc_inc2;
          end
          r_state <= S_FETCH;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FETCH_CYCLE_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= 16'd0;
    end else if ((r_state == S_IDLE || r_state == S_HALT) && start) begin
      cycle_cnt <= 16'd0;
    end else if (busy && cycle_cnt != 16'hFFFF) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
